// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator with a one-cycle pixel-fetch
// pipeline. Horizontal and vertical counters sweep through the active,
// front porch, sync and back porch phases.
//
// Stage 0 presents the pixel coordinate to the frame-buffer reader.
// Stage 1 drives sync, data-enable and colour to the DAC pins, all aligned
// on the same cycle.
//
// Optional feature macro: VGA_TIMING_TESTPAT_EN
//   When defined, the block ignores pix_r/g/b. Stage 1 instead shows an
//   internal test pattern:
//     red   = x[7:0]
//     green = y[7:0]
//     blue  = 8'hFF on the border pixels, otherwise 0
//
// Ports
//   clock        pixel clock
//   reset        synchronous, active-high
//   enable       pixel-clock enable; all state holds while low
//   pix_x/pix_y  requested coordinate (0 outside the active area)
//   pix_req      coordinate valid, active area only
//   pix_r/g/b    fetched colour, sampled one enabled cycle after pix_req
//   line_start   one-cycle pulse for h_cnt==0
//   frame_start  one-cycle pulse for h_cnt==0 and v_cnt==0
//   vga_hsync    horizontal sync at the configured polarity
//   vga_vsync    vertical sync at the configured polarity
//   vga_de       output data enable
//   vga_r/g/b    output colour
//
// CW must be at least 8 and must hold H_TOTAL-1 and V_TOTAL-1.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_req,
  input  logic [7:0]    pix_r,
  input  logic [7:0]    pix_g,
  input  logic [7:0]    pix_b,
  output logic          line_start,
  output logic          frame_start,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_de,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_FP_START   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_BP_START   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_FP_START   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BP_START   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_LAST       = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST       = CW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  // The phase is decoded from the counter value the state is about to
  // hold. A zero-width phase therefore has an empty count range and is
  // never entered; the FSM steps straight to the following phase.
  function automatic phase_t h_phase_of(input logic [CW-1:0] cnt);
    if (cnt < H_FP_START)        return PH_ACTIVE;
    else if (cnt < H_SYNC_START) return PH_FP;
    else if (cnt < H_BP_START)   return PH_SYNC;
    else                         return PH_BP;
  endfunction

  function automatic phase_t v_phase_of(input logic [CW-1:0] cnt);
    if (cnt < V_FP_START)        return PH_ACTIVE;
    else if (cnt < V_SYNC_START) return PH_FP;
    else if (cnt < V_BP_START)   return PH_SYNC;
    else                         return PH_BP;
  endfunction

  logic [CW-1:0] h_cnt, h_cnt_next;
  logic [CW-1:0] v_cnt, v_cnt_next;
  phase_t        h_state, h_state_next;
  phase_t        v_state, v_state_next;

  logic          hs0, vs0, de0;
  logic          active;
  logic [7:0]    col_r, col_g, col_b;

  // Raster counters and phase state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= h_phase_of('0);
      v_state <= v_phase_of('0);
    end else begin
      h_cnt   <= h_cnt_next;
      v_cnt   <= v_cnt_next;
      h_state <= h_state_next;
      v_state <= v_state_next;
    end
  end

  // Next-state logic.
  // v_cnt advances only on the cycle where h_cnt wraps, so vsync edges
  // always land on line boundaries.
  always_comb begin
    h_cnt_next   = h_cnt;
    v_cnt_next   = v_cnt;
    h_state_next = h_state;
    v_state_next = v_state;
    if (enable) begin
      if (h_cnt == H_LAST) begin
        h_cnt_next = '0;
        if (v_cnt == V_LAST) v_cnt_next = '0;
        else                 v_cnt_next = v_cnt + 1'b1;
      end else begin
        h_cnt_next = h_cnt + 1'b1;
      end
      h_state_next = h_phase_of(h_cnt_next);
      v_state_next = v_phase_of(v_cnt_next);
    end
  end

  assign active = (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);

  // Stage 0: coordinate request, internal sync/de and the frame pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_req     <= 1'b0;
      hs0         <= 1'b0;
      vs0         <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      pix_x       <= active ? h_cnt : '0;
      pix_y       <= active ? v_cnt : '0;
      pix_req     <= active;
      hs0         <= (h_state == PH_SYNC);
      vs0         <= (v_state == PH_SYNC);
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign de0 = pix_req;

`ifdef VGA_TIMING_TESTPAT_EN
  // The pattern uses the stage-0 coordinates, so it lines up with the
  // sync outputs exactly as fetched colour would.
  logic border;
  assign border = (pix_x == '0) || (pix_x == X_LAST) ||
                  (pix_y == '0) || (pix_y == Y_LAST);
  assign col_r  = pix_x[7:0];
  assign col_g  = pix_y[7:0];
  assign col_b  = border ? 8'hFF : 8'h00;
`else
  assign col_r = pix_r;
  assign col_g = pix_g;
  assign col_b = pix_b;
`endif

  // Stage 1: pin-facing registers.
  // Colour is forced to zero outside the data-enable window so the DAC
  // sees black during blanking, whatever the fetch path returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_hsync <= ~HS_POL;
      vga_vsync <= ~VS_POL;
      vga_de    <= 1'b0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else if (enable) begin
      vga_hsync <= hs0 ? HS_POL : ~HS_POL;
      vga_vsync <= vs0 ? VS_POL : ~VS_POL;
      vga_de    <= de0;
      vga_r     <= de0 ? col_r : 8'h00;
      vga_g     <= de0 ? col_g : 8'h00;
      vga_b     <= de0 ? col_b : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen in a small test mode:
//   horizontal: 4 active, 1 front porch, 2 sync, 1 back porch (8 per line)
//   vertical:   3 active, 1 front porch, 1 sync, 1 back porch (6 lines)
//   hsync is active-low and vsync is active-high.
//
// The fetch path returns:
//   red   = x + 0x10
//   green = y + 0x20
//   blue  = 0x5A (constant)
//
// Expected outputs follow from the number of enabled cycles since reset.
// Stage 0 shows raster count n-1, and stage 1 shows raster count n-2.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CW = 12;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_req;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic          line_start, frame_start;
  logic          vga_hsync, vga_vsync, vga_de;
  logic [7:0]    vga_r, vga_g, vga_b;

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_req(pix_req),
    .pix_r(pix_r),
    .pix_g(pix_g),
    .pix_b(pix_b),
    .line_start(line_start),
    .frame_start(frame_start),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_de(vga_de),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A frame buffer stand-in that answers from the requested coordinate.
  assign pix_r = pix_x[7:0] + 8'h10;
  assign pix_g = pix_y[7:0] + 8'h20;
  assign pix_b = 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_count = check_count + 1;
    assert (obs === expv) pass_count = pass_count + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Drive the inputs, take one clock edge, and settle before sampling.
  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
    @(posedge clock);
    #1;
    if (rst)     cyc = 0;
    else if (en) cyc = cyc + 1;
  endtask

  // Compare every output against the raster position implied by cyc.
  task automatic checkOutput();
    int m0, h0, v0, m1, h1, v1;
    logic ereq, ede;
    logic [31:0] ex, ey, els, efs, ehs, evs, er, eg, eb;
    ereq = 1'b0; ex = 0; ey = 0; els = 0; efs = 0;
    ede  = 1'b0; ehs = 1; evs = 0; er = 0; eg = 0; eb = 0;
    if (cyc >= 1) begin
      m0   = (cyc - 1) % 48;
      h0   = m0 % 8;
      v0   = m0 / 8;
      ereq = (h0 < 4) && (v0 < 3);
      ex   = ereq ? h0 : 0;
      ey   = ereq ? v0 : 0;
      els  = (h0 == 0) ? 1 : 0;
      efs  = (m0 == 0) ? 1 : 0;
    end
    if (cyc >= 2) begin
      m1  = (cyc - 2) % 48;
      h1  = m1 % 8;
      v1  = m1 / 8;
      ede = (h1 < 4) && (v1 < 3);
      ehs = (h1 == 5 || h1 == 6) ? 0 : 1;
      evs = (v1 == 4) ? 1 : 0;
      er  = ede ? h1 + 32'h10 : 0;
      eg  = ede ? v1 + 32'h20 : 0;
      eb  = ede ? 32'h5A : 0;
    end
    chk("pix_req",     32'(pix_req),     32'(ereq));
    chk("pix_x",       32'(pix_x),       ex);
    chk("pix_y",       32'(pix_y),       ey);
    chk("line_start",  32'(line_start),  els);
    chk("frame_start", 32'(frame_start), efs);
    chk("vga_hsync",   32'(vga_hsync),   ehs);
    chk("vga_vsync",   32'(vga_vsync),   evs);
    chk("vga_de",      32'(vga_de),      32'(ede));
    chk("vga_r",       32'(vga_r),       er);
    chk("vga_g",       32'(vga_g),       eg);
    chk("vga_b",       32'(vga_b),       eb);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput();
    end

    $display("[TB] free-run just over two frames");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
    end
    chk("at_x_2", 32'(pix_x), 32'd2);
    chk("at_y_1", 32'(pix_y), 32'd1);

    $display("[TB] enable low for 5 cycles at (2,1)");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput();
      chk("frozen_x", 32'(pix_x), 32'd2);
      chk("frozen_r", 32'(vga_r), 32'h11);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput();
    chk("resume_x", 32'(pix_x), 32'd3);
    chk("resume_y", 32'(pix_y), 32'd1);
    chk("resume_r", 32'(vga_r), 32'h12);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
    end
    chk("at_x_3", 32'(pix_x), 32'd3);
    chk("at_y_2", 32'(pix_y), 32'd2);

    $display("[TB] reset at (3,2) with enable high");
    applyStimulus(1'b1, 1'b1);
    checkOutput();
    chk("rst_hsync", 32'(vga_hsync), 32'd1);
    chk("rst_vsync", 32'(vga_vsync), 32'd0);
    chk("rst_de",    32'(vga_de),    32'd0);

    applyStimulus(1'b0, 1'b1);
    checkOutput();
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_x",  32'(pix_x),       32'd0);
    chk("restart_y",  32'(pix_y),       32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a one-cycle pixel-fetch pipeline, replacing the fixed 1280x1024 hsync-only generator in the scope display path. It sweeps horizontal and vertical counters through active, front porch, sync and back porch phases, and presents pixel coordinates to the frame-buffer reader. It then returns sync, data-enable and RGB to the DAC pins, aligned on the same cycle. Sync polarities and all porch and sync widths are parameters, so one block serves every supported mode.

## Interface

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, hsync pulse width (clocks)
- H_BP, 248, horizontal back porch (clocks)
- V_ACTIVE, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 38, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- CW, 12, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clock  in  1  pixel clock (108 MHz for the default mode)
- reset  in  1  synchronous, active-high
- enable  in  1  pixel-clock enable; when low, all state holds
- pix_x  out  CW  requested column, 0..H_ACTIVE-1
- pix_y  out  CW  requested line, 0..V_ACTIVE-1
- pix_req  out  1  coordinate valid, high in the active area only
- pix_r, pix_g, pix_b  in  8 each  fetched colour, sampled one enabled cycle after pix_req
- line_start  out  1  one-cycle pulse at h_cnt==0
- frame_start  out  1  one-cycle pulse at h_cnt==0 and v_cnt==0
- vga_hsync, vga_vsync  out  1 each  sync outputs, already at the configured polarity
- vga_de  out  1  output data enable
- vga_r, vga_g, vga_b  out  8 each  output colour

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_ parameters.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1, and wraps to 0.
- The horizontal phase FSM is ACTIVE→FP→SYNC→BP→ACTIVE:
  - ACTIVE: h_cnt < H_ACTIVE
  - FP: H_ACTIVE ≤ h_cnt < H_ACTIVE+H_FP
  - SYNC: the next H_SYNC counts
  - BP: the remaining counts
- The vertical phases follow the same rule on v_cnt.
- A phase with zero width is skipped; the FSM transitions directly to the following phase.
- Stage 0 (registered from the counters): pix_x=h_cnt, pix_y=v_cnt, pix_req = H_ACTIVE and V_ACTIVE. Internal hs0, vs0 and de0 are produced in this stage. pix_x and pix_y are 0 while pix_req is low.
- Stage 1 carries the stage-0 signals one enabled cycle later:
  - vga_hsync = hs0 ? HS_POL : !HS_POL; vga_vsync uses VS_POL the same way.
  - vga_de = de0.
  - vga_r/g/b = de0 ? pix_r/g/b : 0.
- vsync asserts and deasserts on line boundaries, coincident with the line_start of those lines.

## Timing

- Reset state:
  - h_cnt, v_cnt, pix_x, pix_y = 0
  - pix_req, vga_de, line_start, frame_start = 0
  - vga_r/g/b = 0
  - vga_hsync = !HS_POL, vga_vsync = !VS_POL
- The first enabled cycle after reset releases gives pix_req=1, coordinates (0,0), frame_start=1 and line_start=1.
- Latency from coordinate to pins: exactly 1 enabled cycle. The external fetch must return colour within that cycle.
- enable low: counters, both stages and the pulses all freeze. A pulse remains high if it was high when enable fell, and is counted once on resume.
- reset mid-frame: reset overrides enable, returns everything to the reset state within 1 cycle, and the raster restarts at (0,0).
- Frame period is H_TOTAL*V_TOTAL enabled cycles. Line period is H_TOTAL.

## Configuration

- VGA_TIMING_TESTPAT_EN defined: the block ignores pix_r/g/b. Stage 1 outputs an internal pattern:
  - vga_r = x[7:0]
  - vga_g = y[7:0]
  - vga_b = 8'hFF when x or y is on the border (x==0, x==H_ACTIVE-1, y==0, y==V_ACTIVE-1), otherwise 0
  - The pattern is zeroed outside de0. Its coordinates are stage-0 values, so latency is unchanged.
- Undefined: colour passes through from pix_r/g/b as described above, with no pattern logic.

## Test plan

Small test mode for the bench: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); HS_POL=0, VS_POL=1.

- Reset then free-run → frame_start every 48 cycles; line_start every 8 cycles; pix_req high for 4 of every 8 cycles on lines 0-2 only.
- Horizontal sync → vga_hsync low on stage-1 cycles for h_cnt 5,6, high elsewhere; vga_de high for h_cnt 0-3 delayed by 1 cycle.
- Vertical sync → vga_vsync high for exactly the 8 cycles of line 4, delayed by 1.
- Drive pix_r = pix_x+0x10 → vga_r on successive active cycles reads 0x10, 0x11, 0x12, 0x13, then 0 during blanking.
- enable low for 5 cycles mid-line at (2,1) → all outputs frozen; on resume, the sequence continues at (3,1) with no skipped or repeated coordinate.
- Assert reset at (3,2) → next cycle vga_hsync=1, vga_vsync=0, vga_de=0; after release, frame_start=1 and coordinates are (0,0).
